// File: rtl/multi_timer_if.sv
// CPU data-memory bus slice seen by the multi-channel timer.
// The master side drives the address, data and strobes; the slave side returns read data and the decode hit.
interface multi_timer_if;
    logic [31:0] data;
    logic [31:0] address;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] rdata;
    logic        TimerAddress;

    modport master (
        output data, address, MemRead, MemWrite,
        input  rdata, TimerAddress
    );

    modport slave (
        input  data, address, MemRead, MemWrite,
        output rdata, TimerAddress
    );
endinterface

// File: rtl/multi_timer.sv
// Free-running counter with NUM_CH compare channels (one-shot or periodic auto-reload), each with a pending bit.
// Exposes an MMIO register window and a combined interrupt line for the coprocessor-0 logic.
module multi_timer #(
    parameter int          NUM_CH    = 4,
    parameter int          WIDTH     = 32,
    parameter logic [31:0] BASE_ADDR = 32'hffff0100
) (
    input  logic              clock,
    input  logic              reset,
    multi_timer_if.slave      bus,
    output logic              TimerInterrupt,
    output logic [NUM_CH-1:0] irq
);

    logic [WIDTH-1:0]  r_count;
    logic [WIDTH-1:0]  r_cmp    [NUM_CH];
    logic [WIDTH-1:0]  r_period [NUM_CH];
    logic [NUM_CH-1:0] r_enable;
    logic [NUM_CH-1:0] r_ie;
    logic [NUM_CH-1:0] r_periodic;
    logic [NUM_CH-1:0] r_pending;

    logic [31:0]       w_offset;
    logic              w_hit;
    logic [31:0]       w_rd_sel;
    logic [31:0]       w_ctrl;
    logic              w_wr_count;
    logic              w_wr_status;
    logic              w_wr_ctrl;
    logic [NUM_CH-1:0] w_wr_cmp;
    logic [NUM_CH-1:0] w_wr_period;
    logic [NUM_CH-1:0] w_match;
    logic [NUM_CH-1:0] w_clr;

    // Address decode, read-data select and per-register write strobes
    always_comb begin
        w_offset    = bus.address - BASE_ADDR;
        w_hit       = 1'b0;
        w_rd_sel    = 32'd0;
        w_wr_count  = 1'b0;
        w_wr_status = 1'b0;
        w_wr_ctrl   = 1'b0;
        w_wr_cmp    = {NUM_CH{1'b0}};
        w_wr_period = {NUM_CH{1'b0}};
        w_ctrl      = 32'd0;
        w_ctrl[NUM_CH-1:0]   = r_enable;
        w_ctrl[16 +: NUM_CH] = r_periodic;
        if (w_offset == 32'h0000_0000) begin
            w_hit      = 1'b1;
            w_rd_sel   = 32'(r_count);
            w_wr_count = bus.MemWrite;
        end else if (w_offset == 32'h0000_0004) begin
            w_hit       = 1'b1;
            w_rd_sel    = 32'(r_pending);
            w_wr_status = bus.MemWrite;
        end else if (w_offset == 32'h0000_0008) begin
            w_hit     = 1'b1;
            w_rd_sel  = w_ctrl;
            w_wr_ctrl = bus.MemWrite;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_offset == 32'(16 + 8 * i)) begin
                    w_hit       = 1'b1;
                    w_rd_sel    = 32'(r_cmp[i]);
                    w_wr_cmp[i] = bus.MemWrite;
                end else if (w_offset == 32'(20 + 8 * i)) begin
                    w_hit          = 1'b1;
                    w_rd_sel       = 32'(r_period[i]);
                    w_wr_period[i] = bus.MemWrite;
                end else begin
                    w_hit = w_hit;
                end
            end
        end
    end

    // Compare match per channel and the W1C clear mask
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_match[i] = r_enable[i] & (r_count == r_cmp[i]);
        end
        if (w_wr_status) begin
            w_clr = bus.data[NUM_CH-1:0];
        end else begin
            w_clr = {NUM_CH{1'b0}};
        end
    end

    assign bus.TimerAddress = w_hit;
    assign bus.rdata        = (bus.MemRead & w_hit) ? w_rd_sel : 32'd0;
    assign irq              = r_pending & r_ie;
    assign TimerInterrupt   = |irq;

    // Free-running counter; a CPU write replaces the increment
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= {WIDTH{1'b0}};
        end else if (w_wr_count) begin
            r_count <= bus.data[WIDTH-1:0];
        end else begin
            r_count <= r_count + WIDTH'(1'b1);
        end
    end

    // Channel state. r_enable arms the comparator and is what CTRL reads back; r_ie is the
    // interrupt mask, set only by CTRL writes, so a one-shot disarm keeps its interrupt visible.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_enable   <= {NUM_CH{1'b0}};
            r_ie       <= {NUM_CH{1'b0}};
            r_periodic <= {NUM_CH{1'b0}};
            r_pending  <= {NUM_CH{1'b0}};
            for (int i = 0; i < NUM_CH; i++) begin
                r_cmp[i]    <= {WIDTH{1'b1}};
                r_period[i] <= {WIDTH{1'b0}};
            end
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_match;
            if (w_wr_ctrl) begin
                r_enable   <= bus.data[NUM_CH-1:0];
                r_ie       <= bus.data[NUM_CH-1:0];
                r_periodic <= bus.data[16 +: NUM_CH];
            end else begin
                r_enable <= r_enable & ~(w_match & ~r_periodic);
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_wr_cmp[i]) begin
                    r_cmp[i] <= bus.data[WIDTH-1:0];
                end else if (w_match[i] & r_periodic[i]) begin
                    r_cmp[i] <= r_cmp[i] + r_period[i];
                end else begin
                    r_cmp[i] <= r_cmp[i];
                end
                if (w_wr_period[i]) begin
                    r_period[i] <= bus.data[WIDTH-1:0];
                end else begin
                    r_period[i] <= r_period[i];
                end
            end
        end
    end

endmodule
